// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch bus: valid/ready request, valid-only response.
// master = fetch stage, slave = instruction memory.
interface if_fetch_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Fetch stage: owns the PC, one outstanding imem fetch, feeds IF/ID.
// Define PERF_CNT_EN to add fetch_count/kill_count counters.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    if_fetch_stage_if.master imem,
    output logic             valid_if,
    output logic [31:0]      npc_if,
    output logic [31:0]      instr_if
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]      fetch_count,
    output logic [31:0]      kill_count
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] instr_q, instr_d;
    logic        kill_q, kill_d;
    logic        valid_q, valid_d;
    logic        req_fire;
    logic        rsp_take;
    logic        rsp_drop;
    logic        in_wait;

    assign in_wait  = (state_q == S_WAIT);
    assign req_fire = imem.imem_req_valid && imem.imem_req_ready;
    assign rsp_take = in_wait && imem.imem_rsp_valid
                      && !kill_q && !redirect_valid;
    assign rsp_drop = in_wait && imem.imem_rsp_valid && !rsp_take;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ: begin
                if (!redirect_valid && req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // redirect without a response stays here and arms kill
                if (rsp_take) begin
                    state_d = S_HOLD;
                end else if (rsp_drop) begin
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    state_d = S_REQ;
                end else if (!id_stall) begin
                    state_d = req_fire ? S_WAIT : S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        imem.imem_req_valid = 1'b0;
        unique case (state_q)
            S_REQ:   imem.imem_req_valid = !redirect_valid;
            S_HOLD:  imem.imem_req_valid = !redirect_valid && !id_stall;
            default: imem.imem_req_valid = 1'b0;
        endcase
    end

    assign imem.imem_addr = pc_q & ~32'd3;
    assign valid_if       = valid_q;
    assign npc_if         = npc_q;
    assign instr_if       = instr_q;

    always_comb begin
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        npc_d    = npc_q;
        instr_d  = instr_q;
        kill_d   = kill_q;
        valid_d  = valid_q;
        if (req_fire) begin
            req_pc_d = pc_q;
        end
        if (rsp_take) begin
            instr_d = imem.imem_rsp_data;
            npc_d   = req_pc_q + PC_STEP;
            pc_d    = req_pc_q + PC_STEP;
            valid_d = 1'b1;
        end
        if (state_q == S_HOLD && !id_stall) begin
            valid_d = 1'b0;
            instr_d = 32'd0;
        end
        if (rsp_drop && kill_q) begin
            kill_d = 1'b0;
        end
        // redirect overrides both capture and the held instruction
        if (redirect_valid) begin
            pc_d    = redirect_pc & ~32'd3;
            valid_d = 1'b0;
            instr_d = 32'd0;
            if (in_wait && !imem.imem_rsp_valid) begin
                kill_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            req_pc_q <= 32'd0;
            npc_q    <= 32'd0;
            instr_q  <= 32'd0;
            kill_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            npc_q    <= npc_d;
            instr_q  <= instr_d;
            kill_q   <= kill_d;
            valid_q  <= valid_d;
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] kill_cnt_q, kill_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, rsp_take};
        kill_cnt_d  = kill_cnt_q + {31'd0, rsp_drop};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= 32'd0;
            kill_cnt_q  <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign kill_count  = kill_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios then random traffic,
// checked against a transaction-level fetch model.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic        id_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        valid_if;
    logic [31:0] npc_if;
    logic [31:0] instr_if;
`ifdef PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] kill_count;
`endif

    if_fetch_stage_if imem ();

    if_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .id_stall       (id_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem),
        .valid_if       (valid_if),
        .npc_if         (npc_if),
        .instr_if       (instr_if)
`ifdef PERF_CNT_EN
        ,
        .fetch_count    (fetch_count),
        .kill_count     (kill_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // fetch model: architectural next PC, one in-flight fetch,
    // staleness of that fetch, and the instruction held for decode
    logic [31:0] exp_pc;
    logic [31:0] exp_npc;
    logic [31:0] exp_instr;
    logic [31:0] infl_addr;
    bit          infl;
    bit          stale;
    bit          exp_valid;
    int          fetches;
    int          kills;
    bit          last_acc;
    bit          vprev;
    logic [31:0] acc_log[$];
    logic [31:0] cap_log[$];

    // memory responder
    int unsigned lat;
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    bit          ovr_en;
    logic [31:0] ovr_data;

    int          n;
    int          na;
    int          nc;
    logic [31:0] h;
    logic [31:0] kc0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc    = 32'd0;
        exp_npc   = 32'd0;
        exp_instr = 32'd0;
        infl      = 1'b0;
        stale     = 1'b0;
        exp_valid = 1'b0;
        fetches   = 0;
        kills     = 0;
        last_acc  = 1'b0;
        vprev     = 1'b0;
        mem_busy  = 1'b0;
        mem_cnt   = 0;
        acc_log.delete();
        cap_log.delete();
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = 32'd0;
    endtask

    // one clock: drive at posedge+1, check at negedge, update memory
    task automatic cycle(input bit st, input bit rdy,
                         input bit rd, input logic [31:0] tgt);
        bit          exp_rv;
        bit          acc;
        bit          rsp;
        logic [31:0] rdata;
        id_stall            = st;
        imem.imem_req_ready = rdy;
        redirect_valid      = rd;
        redirect_pc         = tgt;
        @(negedge clk);
        exp_rv = !rd && !infl && !(exp_valid && st);
        check("req_valid", 32'(imem.imem_req_valid), 32'(exp_rv));
        if (exp_rv) check("imem_addr", imem.imem_addr, exp_pc);
        check("valid_if", 32'(valid_if), 32'(exp_valid));
        check("instr_if", instr_if, exp_valid ? exp_instr : 32'd0);
        if (exp_valid) check("npc_if", npc_if, exp_npc);
`ifdef PERF_CNT_EN
        check("fetch_count", fetch_count, 32'(fetches));
        check("kill_count", kill_count, 32'(kills));
`endif
        if (valid_if && !vprev) cap_log.push_back(npc_if);
        vprev = valid_if;
        acc   = exp_rv && rdy;
        if (acc) acc_log.push_back(imem.imem_addr);
        rsp   = imem.imem_rsp_valid;
        rdata = imem.imem_rsp_data;
        if (exp_valid && (!st || rd)) exp_valid = 1'b0;
        if (rsp && infl) begin
            infl = 1'b0;
            if (stale || rd) begin
                kills++;
            end else begin
                exp_valid = 1'b1;
                exp_instr = rdata;
                exp_npc   = infl_addr + 32'd4;
                exp_pc    = exp_npc;
                fetches++;
            end
        end
        if (acc) begin
            infl      = 1'b1;
            stale     = 1'b0;
            infl_addr = exp_pc;
        end
        if (rd) begin
            exp_pc = tgt & ~32'd3;
            if (infl) stale = 1'b1;
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        if (rsp) mem_busy = 1'b0;
        if (acc) begin
            mem_busy = 1'b1;
            mem_cnt  = int'(lat);
            mem_addr = infl_addr;
        end
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = $urandom;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem.imem_rsp_valid = 1'b1;
                imem.imem_rsp_data  = ovr_en ? ovr_data
                                    : (mem_addr ^ 32'hA5A5_0000);
            end
        end
    endtask

    initial begin
        rst                 = 1'b0;
        id_stall            = 1'b0;
        redirect_valid      = 1'b0;
        redirect_pc         = 32'd0;
        imem.imem_req_ready = 1'b0;
        lat                 = 1;
        ovr_en              = 1'b0;
        ovr_data            = 32'd0;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(valid_if), 32'd0);
        check("rst_instr", instr_if, 32'd0);
        check("rst_npc", npc_if, 32'd0);
        check("rst_addr", imem.imem_addr, 32'd0);
        check("rst_req", 32'(imem.imem_req_valid), 32'd1);
`ifdef PERF_CNT_EN
        check("rst_fcnt", fetch_count, 32'd0);
        check("rst_kcnt", kill_count, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;

        // sequential fetch, zero-wait memory
        repeat (8) cycle(1'b0, 1'b1, 1'b0, 32'd0);
        check("seq_n", 32'(acc_log.size() >= 3 && cap_log.size() >= 3),
              32'd1);
        if (acc_log.size() >= 3 && cap_log.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                check("seq_addr", acc_log[i], 32'(4 * i));
                check("seq_npc", cap_log[i], 32'(4 * i + 4));
            end
        end

        // stall while holding a known instruction
        ovr_data = 32'h2001_0005;
        ovr_en   = 1'b1;
        n = 0;
        while (!(exp_valid && exp_instr == ovr_data) && n < 12) begin
            cycle(1'b0, 1'b1, 1'b0, 32'd0);
            n++;
        end
        check("stall_instr", instr_if, 32'h2001_0005);
        h = npc_if;
        repeat (5) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        ovr_en = 1'b0;
        na = acc_log.size();
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        check("rel_n", 32'(acc_log.size()), 32'(na + 1));
        if (acc_log.size() > na) check("rel_addr", acc_log[na], h);

        // redirect one cycle after acceptance, 3-cycle memory
        lat = 3;
        n = 0;
        do begin
            cycle(1'b0, 1'b1, 1'b0, 32'd0);
            n++;
        end while (!last_acc && n < 10);
        check("p3_acc", 32'(last_acc), 32'd1);
`ifdef PERF_CNT_EN
        kc0 = kill_count;
`else
        kc0 = 32'd0;
`endif
        na = acc_log.size();
        nc = cap_log.size();
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_0103);
        n = 0;
        while (acc_log.size() == na && n < 12) begin
            cycle(1'b0, 1'b1, 1'b0, 32'd0);
            n++;
        end
        check("p3_n", 32'(acc_log.size()), 32'(na + 1));
        if (acc_log.size() > na) check("p3_addr", acc_log[na], 32'h100);
        check("p3_novalid", 32'(cap_log.size()), 32'(nc));
`ifdef PERF_CNT_EN
        check("p3_kill", kill_count - kc0, 32'd1);
`endif

        // redirect coincident with response, then back-pressure
        lat = 2;
        n = 0;
        while (!imem.imem_rsp_valid && n < 12) begin
            cycle(1'b0, 1'b1, 1'b0, 32'd0);
            n++;
        end
        check("p4_rsp", 32'(imem.imem_rsp_valid), 32'd1);
        nc = cap_log.size();
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 32'd0);
        na = acc_log.size();
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        check("p4_n", 32'(acc_log.size()), 32'(na + 1));
        if (acc_log.size() > na) check("p4_addr", acc_log[na], 32'h200);
        check("p4_novalid", 32'(cap_log.size()), 32'(nc));

        // PC wrap
        lat = 1;
        nc = cap_log.size();
        cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        n = 0;
        while (cap_log.size() == nc && n < 12) begin
            cycle(1'b0, 1'b1, 1'b0, 32'd0);
            n++;
        end
        check("wrap_n", 32'(cap_log.size()), 32'(nc + 1));
        if (cap_log.size() > nc) check("wrap_npc", cap_log[nc], 32'd0);
        repeat (4) cycle(1'b0, 1'b1, 1'b0, 32'd0);

        // async reset in the middle of S_WAIT
        lat = 3;
        n = 0;
        do begin
            cycle(1'b0, 1'b1, 1'b0, 32'd0);
            n++;
        end while (!last_acc && n < 10);
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid", 32'(valid_if), 32'd0);
        check("ar_instr", instr_if, 32'd0);
        check("ar_npc", npc_if, 32'd0);
        check("ar_addr", imem.imem_addr, 32'd0);
        check("ar_req", 32'(imem.imem_req_valid), 32'd1);
`ifdef PERF_CNT_EN
        check("ar_fcnt", fetch_count, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        lat = 1;
        repeat (6) cycle(1'b0, 1'b1, 1'b0, 32'd0);
        check("ar_n", 32'(acc_log.size() >= 1), 32'd1);
        if (acc_log.size() >= 1) check("ar_first", acc_log[0], 32'd0);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] tgt;
            lat = $urandom_range(1, 3);
            tgt = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            end
            cycle($urandom_range(0, 9) < 3,
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 19) == 0,
                  tgt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
